// File: rtl/icache_direct_if.sv
// Fetch-port and line-refill bus of the direct-mapped instruction cache.
// The cache uses the slave view; the core plus instruction memory use the master view.
interface icache_direct_if #(
  parameter int ADDR_W = 32
);
  logic              proc_req;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport slave (
    input  proc_req, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_req, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-word line refill on a miss.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_direct #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 4;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-5:0]   miss_addr_q, miss_addr_d;
  logic                mem_read_q, mem_read_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [127:0]        data_q [LINES];

  logic [1:0]          offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;
  logic                fill_we;

  assign offset   = bus.proc_addr[3:2];
  assign index    = bus.proc_addr[IDX_W+3:4];
  assign tag      = bus.proc_addr[ADDR_W-1:IDX_W+4];
  assign fill_idx = miss_addr_q[IDX_W-1:0];
  assign fill_tag = miss_addr_q[ADDR_W-5:IDX_W];
  assign hit      = bus.proc_req && valid_q[index] && (tag_q[index] == tag);
  assign fill_we  = (state_q == FETCH) && bus.mem_ready && !rst;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    mem_read_d  = mem_read_q;
    valid_d     = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.proc_req && !hit) begin
          state_d     = FETCH;
          miss_addr_d = bus.proc_addr[ADDR_W-1:4];
          mem_read_d  = 1'b1;
        end
      end
      FETCH: begin
        if (bus.mem_ready) begin
          state_d           = FILL;
          mem_read_d        = 1'b0;
          valid_d[fill_idx] = 1'b1;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mem_read_q  <= mem_read_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays are deliberately not reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_idx] <= bus.mem_rdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  always_comb begin
    bus.proc_rdata = '0;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_addr   = '0;
    if (!rst) begin
      bus.mem_read = mem_read_q;
      if (mem_read_q) bus.mem_addr = {miss_addr_q, 4'b0000};
      if (state_q == IDLE) begin
        bus.proc_stall = bus.proc_req && !hit;
        if (hit) bus.proc_rdata = data_q[index][{offset, 5'b00000} +: 32];
      end else begin
        bus.proc_stall = 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && hit && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == IDLE && bus.proc_req && !hit && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table, reset/idle sequences,
// and randomized fetches against a line-level cache model.
module tb_icache_direct;
  localparam int LINES  = 8;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = $clog2(LINES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_direct_if #(.ADDR_W(ADDR_W)) bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_direct #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit          model_valid [LINES];
  logic [31:0] model_tag   [LINES];
  int          model_hits;
  int          model_misses;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          exp_stalls;
    logic [31:0] exp_mem_addr;
  } vec_t;

  vec_t vecs [6];

  // Instruction memory contents: a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] line_addr, input int w);
    return ((line_addr + 32'(w * 4)) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] line_addr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(line_addr, w);
    return l;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < LINES; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
    end
    model_hits   = 0;
    model_misses = 0;
  endtask

  // A miss costs latency + 2 stalled cycles; every fetch ends with exactly one hit cycle.
  task automatic modelFetch(input logic [31:0] addr, input int lat, output int exp_stalls,
                            output logic [31:0] exp_word, output logic [31:0] exp_line);
    int          idx;
    logic [31:0] t;
    idx      = int'((addr >> 4) % LINES);
    t        = addr >> (4 + IDX_W);
    exp_line = addr & 32'hFFFF_FFF0;
    exp_word = mem_word(exp_line, int'((addr >> 2) % 4));
    if (model_valid[idx] && model_tag[idx] == t) begin
      exp_stalls = 0;
    end else begin
      exp_stalls       = lat + 2;
      model_valid[idx] = 1'b1;
      model_tag[idx]   = t;
      model_misses++;
    end
    model_hits++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Starts just after a negedge; plays the memory side with the given latency and returns
  // just after the negedge that follows the hit cycle.
  task automatic applyStimulus(input logic [31:0] addr, input int lat, output int stalls,
                               output logic [31:0] rdata, output logic [31:0] seen_addr);
    int fc;
    stalls    = 0;
    fc        = 0;
    seen_addr = '0;
    bus.proc_req  = 1'b1;
    bus.proc_addr = addr;
    #1;
    while (bus.proc_stall && stalls < 64) begin
      if (bus.mem_read) begin
        fc++;
        seen_addr = bus.mem_addr;
        if (fc == lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_line(bus.mem_addr);
        end
      end
      stalls++;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
    end
    rdata = bus.proc_rdata;
    @(negedge clk);
  endtask

  task automatic checkedFetch(input string name, input logic [31:0] addr, input int lat);
    int          exp_stalls, stalls;
    logic [31:0] exp_word, exp_line, rdata, seen;
    modelFetch(addr, lat, exp_stalls, exp_word, exp_line);
    applyStimulus(addr, lat, stalls, rdata, seen);
    checkOutput({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
    checkOutput({name, " rdata"}, rdata, exp_word);
    if (exp_stalls != 0) checkOutput({name, " mem_addr"}, seen, exp_line);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          stalls;
    logic [31:0] rdata, seen, exp_word, exp_line, addr;
    int          exp_stalls, lat;

    vecs[0] = '{32'h0001_0000, 2, 4, 32'h0001_0000};
    vecs[1] = '{32'h0001_0004, 1, 0, 32'h0000_0000};
    vecs[2] = '{32'h0001_0008, 1, 0, 32'h0000_0000};
    vecs[3] = '{32'h0001_000C, 1, 0, 32'h0000_0000};
    vecs[4] = '{32'h0001_0080, 1, 3, 32'h0001_0080};
    vecs[5] = '{32'h0001_0000, 3, 5, 32'h0001_0000};

    rst           = 1'b1;
    bus.proc_req  = 1'b1;
    bus.proc_addr = 32'h0001_0000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset proc_stall", 32'(bus.proc_stall), 32'd0);
    checkOutput("reset proc_rdata", bus.proc_rdata, 32'd0);
    checkOutput("reset mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
`ifdef ICACHE_STATS_EN
    checkOutput("reset hit_cnt", hit_cnt, 32'd0);
    checkOutput("reset miss_cnt", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    // Cold miss, line hits, then a same-index conflict and its refetch.
    for (int i = 0; i < 6; i++) begin
      modelFetch(vecs[i].addr, vecs[i].lat, exp_stalls, exp_word, exp_line);
      applyStimulus(vecs[i].addr, vecs[i].lat, stalls, rdata, seen);
      checkOutput($sformatf("vec%0d stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
      checkOutput($sformatf("vec%0d rdata", i), rdata, exp_word);
      if (vecs[i].exp_stalls != 0)
        checkOutput($sformatf("vec%0d mem_addr", i), seen, vecs[i].exp_mem_addr);
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        checkOutput("stats hit_cnt after line hits", hit_cnt, 32'd4);
        checkOutput("stats miss_cnt after line hits", miss_cnt, 32'd1);
      end
`endif
    end

    // Idle cycles with stray mem_ready pulses must change nothing.
    bus.proc_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput($sformatf("idle%0d mem_read", i), 32'(bus.mem_read), 32'd0);
      checkOutput($sformatf("idle%0d proc_stall", i), 32'(bus.proc_stall), 32'd0);
      checkOutput($sformatf("idle%0d proc_rdata", i), bus.proc_rdata, 32'd0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    checkedFetch("after idle 0x00010000", 32'h0001_0000, 1);
    checkedFetch("after idle 0x0001000C", 32'h0001_000C, 1);

    for (int n = 0; n < 150; n++) begin
      addr = 32'h0004_0000 | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
           | (32'($urandom_range(0, 3)) << 2);
      lat  = int'($urandom_range(1, 4));
      checkedFetch($sformatf("rand%0d @%08h", n, addr), addr, lat);
      if ($urandom_range(0, 4) == 0) begin
        bus.proc_req = 1'b0;
        @(negedge clk);
      end
    end
`ifdef ICACHE_STATS_EN
    checkOutput("stats hit_cnt after random", hit_cnt, 32'(model_hits));
    checkOutput("stats miss_cnt after random", miss_cnt, 32'(model_misses));
`endif

    // Reset while a line fetch is outstanding, then a late mem_ready.
    checkedFetch("pre-reset conflict 0x00010080", 32'h0001_0080, 1);
    bus.proc_req  = 1'b1;
    bus.proc_addr = 32'h0001_0000;
    #1;
    checkOutput("midfetch miss stall", 32'(bus.proc_stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("midfetch mem_read", 32'(bus.mem_read), 32'd1);
    checkOutput("midfetch mem_addr", bus.mem_addr, 32'h0001_0000);
    rst          = 1'b1;
    bus.proc_req = 1'b0;
    #1;
    checkOutput("in-reset mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("in-reset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("in-reset proc_stall", 32'(bus.proc_stall), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem_line(32'h0001_0000);
    resetModel();
    #1;
    checkOutput("post-reset mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("post-reset proc_stall", 32'(bus.proc_stall), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("after late ready mem_read", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    checkedFetch("refetch after reset 0x00010000", 32'h0001_0000, 2);
    checkedFetch("hit after refetch 0x00010008", 32'h0001_0008, 1);
`ifdef ICACHE_STATS_EN
    checkOutput("stats hit_cnt after reset", hit_cnt, 32'(model_hits));
    checkOutput("stats miss_cnt after reset", miss_cnt, 32'(model_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CHIP instruction-fetch port and the multi-cycle instruction memory.
- Returns hits combinationally in the same cycle.
- On a miss it stalls the core and fetches a 4-word line over a valid/ready memory handshake.
- Replaces the zero-latency instruction memory so that CHIP can run against realistic, slow text memory.

Parameters:
- LINES, 8, number of cache lines; power of 2, at least 2; IDX_W = log2(LINES).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_req  in  1  fetch request this cycle.
- proc_addr  in  ADDR_W  byte address of the fetched instruction; bits [1:0] ignored.
- proc_rdata  out  32  instruction word; valid when proc_req=1 and proc_stall=0.
- proc_stall  out  1  core must hold the PC and proc_addr.
- mem_read  out  1  line-fetch request to instruction memory.
- mem_addr  out  ADDR_W  line-aligned address, bits [3:0]=0.
- mem_rdata  in  128  line data; word0 in [31:0], word3 in [127:96].
- mem_ready  in  1  one-cycle pulse; mem_rdata is valid in that cycle.

Behaviour:
- Address split:
  - offset = proc_addr[3:2]
  - index = proc_addr[IDX_W+3:4]
  - tag = proc_addr[ADDR_W-1:IDX_W+4]
- Storage per line: valid bit, tag, 4x32 data.
- States: IDLE, FETCH, FILL.
- IDLE:
  - hit = proc_req & valid[index] & (tag match).
  - Hit: proc_rdata = line word[offset], proc_stall=0, combinational in the same cycle.
  - Miss (proc_req & !hit): proc_stall=1 combinationally; latch {tag,index} into miss_addr; next state FETCH.
  - proc_req=0: proc_stall=0; proc_rdata = 0.
- FETCH:
  - mem_read=1 and mem_addr = {miss_addr,4'b0}, both held stable until mem_ready.
  - proc_stall=1.
  - On mem_ready: write mem_rdata, tag and valid=1 into line[miss index]; next state FILL.
- FILL:
  - proc_stall=1 and mem_read=0.
  - Next state IDLE; the core's held address then hits.
- Miss penalty: memory latency (cycles from mem_read rise to mem_ready) + 2 cycles.
  - Example: mem_ready in the first FETCH cycle gives 3 stalled cycles total.
- Stall contract:
  - The core holds proc_addr while proc_stall=1.
  - The fill uses miss_addr, so an upstream violation corrupts nothing; it only costs another miss.
- mem_ready outside FETCH is ignored.
- mem_read is driven from the state register only, never from proc_* inputs.
- Replacement: always overwrite the indexed line; there is no dirty state and no write port.
- Reset (any state, including mid-FETCH):
  - All valid bits cleared; state IDLE.
  - mem_read=0 from the following cycle; a late mem_ready is ignored.
  - Data and tag arrays are not reset.
  - While rst=1: proc_stall=0, proc_rdata=0, mem_read=0, mem_addr=0.
- Cold start: the first fetch after reset always misses.

Optional Feature:
- ICACHE_STATS_EN defined:
  - Extra outputs hit_cnt[31:0] and miss_cnt[31:0], both cleared by rst.
  - hit_cnt increments each IDLE cycle with a hit.
  - miss_cnt increments once per miss, on the IDLE→FETCH transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Cold miss: after reset, proc_req=1, addr 0x00010000, mem_ready 2 cycles after mem_read rises → mem_addr=0x00010000; proc_stall high for 4 cycles; then proc_rdata = word0 of the line.
- Line hits: following the cold miss, addrs 0x00010004/08/0C in consecutive cycles → proc_stall=0; rdata = mem_rdata[63:32], [95:64], [127:96].
- Conflict (LINES=8): fetch 0x00010000, then 0x00010080 (same index, new tag), then 0x00010000 → second and third accesses each miss and refetch; mem_addr = 0x00010080, then 0x00010000.
- Reset mid-FETCH: assert rst while mem_read=1, then pulse mem_ready 1 cycle after rst falls → mem_read=0 after the reset edge, no line written, re-fetching 0x00010000 misses again.
- Idle: proc_req=0 for 5 cycles → mem_read=0, proc_stall=0, no state change.
- With ICACHE_STATS_EN: run the cold-miss and line-hits scenarios back to back → hit_cnt=4 (three line hits plus the post-fill hit), miss_cnt=1.
